// File: rtl/plx_mem_arbiter_if.sv
// plx_mem_arbiter_if: PLX port, event-builder port and memory bus of the arbiter
interface plx_mem_arbiter_if;
   logic        plx_req_i, plx_wr_i, plx_last_i;
   logic [10:0] plx_addr_i;
   logic [31:0] plx_dat_i;
   logic        plx_ack_o, plx_bterm_o;
   logic [31:0] plx_dat_o;
   logic        evt_req_i, evt_wr_i, evt_last_i;
   logic [10:0] evt_addr_i;
   logic [31:0] evt_dat_i;
   logic        evt_ack_o, evt_bterm_o;
   logic [31:0] evt_dat_o;
   logic        mem_en_o, mem_wr_o;
   logic [10:0] mem_addr_o;
   logic [31:0] mem_dat_o, mem_dat_i;
   logic [1:0]  owner_o;

   modport slave (
      input  plx_req_i, plx_wr_i, plx_last_i, plx_addr_i, plx_dat_i,
      output plx_ack_o, plx_bterm_o, plx_dat_o,
      input  evt_req_i, evt_wr_i, evt_last_i, evt_addr_i, evt_dat_i,
      output evt_ack_o, evt_bterm_o, evt_dat_o,
      output mem_en_o, mem_wr_o, mem_addr_o, mem_dat_o,
      input  mem_dat_i,
      output owner_o
   );

   modport master (
      output plx_req_i, plx_wr_i, plx_last_i, plx_addr_i, plx_dat_i,
      input  plx_ack_o, plx_bterm_o, plx_dat_o,
      output evt_req_i, evt_wr_i, evt_last_i, evt_addr_i, evt_dat_i,
      input  evt_ack_o, evt_bterm_o, evt_dat_o,
      input  mem_en_o, mem_wr_o, mem_addr_o, mem_dat_o,
      output mem_dat_i,
      input  owner_o
   );
endinterface

// File: rtl/plx_mem_arbiter.sv
// plx_mem_arbiter: arbitrates PLX and event-builder bursts onto one word memory.
// Define PLX_MEM_ARB_FAIR_EN for round-robin arbitration; otherwise PLX has fixed priority.
module plx_mem_arbiter (
   input  logic             clk_i,
   input  logic             rst_i,
   plx_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, PLX_GNT = 2'b01, EVT_GNT = 2'b10} stateT;

   stateT       state, stateNext;
   logic [10:0] burstAddr, burstAddrNext;
   logic [4:0]  burstCnt, burstCntNext;
   logic        ownReq, ownWr, ownLast, access, anyReq, grantEvt;
   logic [31:0] ownDat;
   logic        ackQ, ackEvtQ, rdQ, btermQ, ackPlx, ackEvt;
   logic [1:0]  ownerQ;

   assign anyReq = bus.plx_req_i | bus.evt_req_i;

`ifdef PLX_MEM_ARB_FAIR_EN
   logic ptrEvt;
   // round-robin pointer: after each grant the other port gets priority
   always_ff @(posedge clk_i) begin
      if (rst_i) ptrEvt <= 1'b0;
      else if (state == IDLE && anyReq) ptrEvt <= ~grantEvt;
   end
   assign grantEvt = bus.evt_req_i & (~bus.plx_req_i | ptrEvt);
`else
   assign grantEvt = bus.evt_req_i & ~bus.plx_req_i;
`endif

   // select the owner's inputs and compute the next burst state
   always_comb begin
      ownReq = state == EVT_GNT ? bus.evt_req_i : state == PLX_GNT ? bus.plx_req_i : 1'b0;
      ownWr = state == EVT_GNT ? bus.evt_wr_i : bus.plx_wr_i;
      ownLast = state == EVT_GNT ? bus.evt_last_i : bus.plx_last_i;
      ownDat = state == EVT_GNT ? bus.evt_dat_i : bus.plx_dat_i;
      access = ownReq & ~rst_i;
      stateNext = state;
      burstAddrNext = burstAddr;
      burstCntNext = burstCnt;
      if (state == IDLE) begin
         if (anyReq) begin
            stateNext = grantEvt ? EVT_GNT : PLX_GNT;
            burstAddrNext = grantEvt ? bus.evt_addr_i : bus.plx_addr_i;
            burstCntNext = 5'd0;
         end
      end else if (!ownReq || ownLast || burstCnt == 5'd15) begin
         stateNext = IDLE;
      end
      if (ownReq) begin
         burstAddrNext = burstAddr + 11'd1;
         burstCntNext = burstCnt + 5'd1;
      end
   end

   // state, burst registers and the one-cycle-delayed acknowledge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         burstAddr <= '0;
         burstCnt <= '0;
         ackQ <= 1'b0;
         ackEvtQ <= 1'b0;
         rdQ <= 1'b0;
         btermQ <= 1'b0;
         ownerQ <= 2'b00;
      end else begin
         state <= stateNext;
         burstAddr <= burstAddrNext;
         burstCnt <= burstCntNext;
         ackQ <= access;
         ackEvtQ <= state == EVT_GNT;
         rdQ <= ~ownWr;
         btermQ <= access & ~ownLast & (burstCnt == 5'd15);
         ownerQ <= stateNext;
      end
   end

   assign ackPlx = ackQ & ~ackEvtQ & ~rst_i;
   assign ackEvt = ackQ & ackEvtQ & ~rst_i;

   assign bus.mem_en_o = access;
   assign bus.mem_wr_o = access & ownWr;
   assign bus.mem_addr_o = access ? burstAddr : '0;
   assign bus.mem_dat_o = access ? ownDat : '0;
   assign bus.plx_ack_o = ackPlx;
   assign bus.evt_ack_o = ackEvt;
   assign bus.plx_bterm_o = ackPlx & btermQ;
   assign bus.evt_bterm_o = ackEvt & btermQ;
   assign bus.plx_dat_o = ackPlx & rdQ ? bus.mem_dat_i : '0;
   assign bus.evt_dat_o = ackEvt & rdQ ? bus.mem_dat_i : '0;
   assign bus.owner_o = rst_i ? 2'b00 : ownerQ;
endmodule

// File: tb/tb_plx_mem_arbiter.sv
// tb_plx_mem_arbiter: burst-level reference model driving directed and random bursts
module tb_plx_mem_arbiter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   nCompared = 0;
   int   nMismatched = 0;
   bit   ptrEvt = 1'b0;
   bit   pendAck = 1'b0, pendWho = 1'b0, pendRd = 1'b0, pendBterm = 1'b0;
   bit   memFixEn = 1'b0;
   logic [31:0] memFix = 32'hA5A5A5A5;
   logic [31:0] dataTab [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
`ifdef PLX_MEM_ARB_FAIR_EN
   bit fair = 1'b1;
`else
   bit fair = 1'b0;
`endif

   plx_mem_arbiter_if bus ();

   plx_mem_arbiter dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic setPort(input bit p, input bit req, input bit wr, input bit last,
                          input logic [10:0] addr, input logic [31:0] dat);
      if (p) begin
         bus.evt_req_i = req; bus.evt_wr_i = wr; bus.evt_last_i = last;
         bus.evt_addr_i = addr; bus.evt_dat_i = dat;
      end else begin
         bus.plx_req_i = req; bus.plx_wr_i = wr; bus.plx_last_i = last;
         bus.plx_addr_i = addr; bus.plx_dat_i = dat;
      end
   endtask

   task automatic driveMem;
      bus.mem_dat_i = memFixEn ? memFix : $urandom;
   endtask

   // acknowledge expected this cycle for the access made in the previous one
   task automatic checkAck;
      bit ap, ae;
      ap = pendAck && !pendWho;
      ae = pendAck && pendWho;
      checkVal("plxAck", 32'(bus.plx_ack_o), 32'(ap));
      checkVal("evtAck", 32'(bus.evt_ack_o), 32'(ae));
      checkVal("plxBterm", 32'(bus.plx_bterm_o), 32'(ap && pendBterm));
      checkVal("evtBterm", 32'(bus.evt_bterm_o), 32'(ae && pendBterm));
      if (!ap || pendRd) checkVal("plxDat", bus.plx_dat_o, ap ? bus.mem_dat_i : 32'd0);
      if (!ae || pendRd) checkVal("evtDat", bus.evt_dat_o, ae ? bus.mem_dat_i : 32'd0);
   endtask

   task automatic idleCycle;
      @(negedge clk_i);
      setPort(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
      setPort(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
      driveMem();
      #1;
      checkAck();
      checkVal("idleEn", 32'(bus.mem_en_o), 32'd0);
      checkVal("idleOwner", 32'(bus.owner_o), 32'd0);
      pendAck = 1'b0;
   endtask

   // one burst: request cycle in IDLE, then accesses until last, 16 words, or an abort
   task automatic doBurst(input bit both, input bit wantEvt, input bit wr, input logic [10:0] a,
                          input int len, input bit useLast, input int abortAt, input bit useTab);
      bit w, lastNow;
      logic [31:0] d;
      w = both ? (fair ? ptrEvt : 1'b0) : wantEvt;
      ptrEvt = !w;
      @(negedge clk_i);
      setPort(w, 1'b1, wr, 1'b0, a, $urandom);
      setPort(!w, both, 1'($urandom), 1'b0, 11'($urandom), $urandom);
      driveMem();
      #1;
      checkAck();
      checkVal("reqEn", 32'(bus.mem_en_o), 32'd0);
      checkVal("reqOwner", 32'(bus.owner_o), 32'd0);
      pendAck = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         driveMem();
         d = useTab && i < 4 ? dataTab[i] : $urandom;
         if (i == abortAt) begin
            setPort(w, 1'b0, wr, 1'b0, 11'($urandom), d);
            setPort(!w, 1'b1, 1'($urandom), 1'b0, 11'($urandom), $urandom);
            #1;
            checkAck();
            checkVal("abortEn", 32'(bus.mem_en_o), 32'd0);
            checkVal("abortOwner", 32'(bus.owner_o), w ? 32'd2 : 32'd1);
            pendAck = 1'b0;
            break;
         end
         lastNow = useLast && i == len - 1;
         setPort(w, 1'b1, wr, lastNow, 11'($urandom), d);
         #1;
         checkAck();
         checkVal("memEn", 32'(bus.mem_en_o), 32'd1);
         checkVal("memWr", 32'(bus.mem_wr_o), 32'(wr));
         checkVal("memAddr", 32'(bus.mem_addr_o), 32'(11'(a + 11'(i))));
         checkVal("memDat", bus.mem_dat_o, d);
         checkVal("owner", 32'(bus.owner_o), w ? 32'd2 : 32'd1);
         pendAck = 1'b1;
         pendWho = w;
         pendRd = !wr;
         pendBterm = i == 15 && !lastNow;
         if (lastNow) break;
      end
   endtask

   task automatic resetMidBurst;
      @(negedge clk_i);
      setPort(1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 32'h11111111);
      driveMem();
      #1;
      checkAck();
      pendAck = 1'b0;
      @(negedge clk_i);
      #1;
      checkVal("rstWord1En", 32'(bus.mem_en_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.plx_dat_i = 32'h22222222;
      #1;
      checkVal("rstEn", 32'(bus.mem_en_o), 32'd0);
      checkVal("rstAck", 32'(bus.plx_ack_o), 32'd0);
      checkVal("rstAddr", 32'(bus.mem_addr_o), 32'd0);
      checkVal("rstOwner", 32'(bus.owner_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      setPort(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
      #1;
      checkVal("postRstEn", 32'(bus.mem_en_o), 32'd0);
      checkVal("postRstAck", 32'(bus.plx_ack_o), 32'd0);
      checkVal("postRstDat", bus.plx_dat_o, 32'd0);
      checkVal("postRstOwner", 32'(bus.owner_o), 32'd0);
      ptrEvt = 1'b0;
   endtask

   initial begin
      setPort(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
      setPort(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
      bus.mem_dat_i = 32'd0;
      repeat (3) @(negedge clk_i);
      #1;
      checkVal("resetEn", 32'(bus.mem_en_o), 32'd0);
      checkVal("resetOwner", 32'(bus.owner_o), 32'd0);
      checkVal("resetPlxAck", 32'(bus.plx_ack_o), 32'd0);
      checkVal("resetEvtAck", 32'(bus.evt_ack_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      doBurst(1'b0, 1'b0, 1'b1, 11'h000, 4, 1'b1, -1, 1'b1);
      idleCycle();
      memFixEn = 1'b1;
      doBurst(1'b0, 1'b0, 1'b0, 11'h7FE, 3, 1'b1, -1, 1'b0);
      idleCycle();
      memFixEn = 1'b0;
      doBurst(1'b0, 1'b1, 1'b1, 11'h040, 20, 1'b0, -1, 1'b0);
      idleCycle();
      repeat (3) doBurst(1'b1, 1'b0, 1'($urandom), 11'($urandom), 3, 1'b1, -1, 1'b0);
      idleCycle();
      doBurst(1'b0, 1'b0, 1'b1, 11'h200, 8, 1'b1, 2, 1'b0);
      doBurst(1'b0, 1'b1, 1'b0, 11'h300, 2, 1'b1, -1, 1'b0);
      idleCycle();
      resetMidBurst();
      for (int k = 0; k < 40; k++) begin
         doBurst(1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) == 0 ? 11'h7F0 + 11'($urandom_range(0, 15)) : 11'($urandom),
                 int'($urandom_range(1, 16)), $urandom_range(0, 3) != 0, -1, 1'b0);
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/plx_mem_arbiter.md
PLX_MEM_ARBITER -- requirements
Module: plx_mem_arbiter

Interface
REQ-001 clk_i  in  1  sole clock; all state and outputs update on its rising edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 plx_req_i  in  1  PLX-side access request; held high for the whole burst.
REQ-004 plx_wr_i / plx_last_i  in  1 / 1  write (1) or read (0); final word of the burst (nBLAST equivalent).
REQ-005 plx_addr_i  in  11  start word address (LA[12:2]), sampled at grant.
REQ-006 plx_dat_i  in  32  write data, one word per access cycle.
REQ-007 plx_ack_o / plx_bterm_o  out  1 / 1  word-complete pulse; forced burst termination.
REQ-008 plx_dat_o  out  32  read data, valid when plx_ack_o is high.
REQ-009 evt_req_i, evt_wr_i, evt_last_i, evt_addr_i[10:0], evt_dat_i[31:0], evt_ack_o, evt_bterm_o, evt_dat_o[31:0]: internal event-builder port with the same meaning as the PLX port.
REQ-010 mem_en_o / mem_wr_o  out  1 / 1  memory access strobe; write enable.
REQ-011 mem_addr_o / mem_dat_o  out  11 / 32  memory address and write data.
REQ-012 mem_dat_i  in  32  memory read data, valid one cycle after mem_en_o.
REQ-013 owner_o  out  2  00 idle, 01 PLX, 10 event port.

Function
REQ-014 FSM states: IDLE, PLX_GNT, EVT_GNT.
REQ-015 IDLE: at a clock edge with any req high, the FSM enters the winning GNT state and latches that port's address into the burst address register.
REQ-016 When both requests are asserted together, arbitration follows REQ-030/031.
REQ-017 GNT state, owner req high: mem_en_o is 1 and mem_wr_o equals the owner's wr_i.
REQ-018 GNT state, owner req high: mem_addr_o equals the burst address register and mem_dat_o equals the owner's dat_i.
REQ-019 The burst address increments by 1 per access, modulo 2^11 (0x7FF wraps to 0x000).
REQ-020 The owner's ack_o pulses exactly one cycle after each access; for reads, dat_o carries mem_dat_i in that cycle.
REQ-021 The non-owner's ack_o, bterm_o and dat_o are 0.
REQ-022 An access with the owner's last_i high is the final access; the FSM returns to IDLE on the next edge, and the trailing ack still issues.
REQ-023 Owner req low in a GNT state aborts the burst: no mem_en_o that cycle, FSM to IDLE on the next edge.
REQ-024 A 5-bit burst counter limits a burst to 16 accesses. After the 16th access without last_i, the FSM returns to IDLE and bterm_o pulses together with that access's ack_o.
REQ-025 After a bterm, the requester re-requests with a new address.
REQ-026 A new grant is issued no earlier than the cycle after IDLE is entered, so there is one idle cycle of turnaround between bursts.
REQ-027 owner_o is a registered copy of the FSM state.

Reset
REQ-028 rst_i high: FSM goes to IDLE, burst counter and address are cleared, and the priority pointer is set to PLX.
REQ-029 rst_i high: all outputs are 0, and the ack of any access outstanding at reset is suppressed, including during a burst.

Configuration
REQ-030 Macro PLX_MEM_ARB_FAIR_EN defined: round-robin arbitration. On simultaneous requests in IDLE, the port that did not own the previous grant wins, and the pointer updates at each grant.
REQ-031 Macro PLX_MEM_ARB_FAIR_EN undefined: fixed priority. PLX always wins on simultaneous requests, and no pointer register exists.

Verification
REQ-032 PLX write burst, addr 0x000, data 01234567/89ABCDEF/FEDCBA98/76543210, last_i on the 4th word -> mem_en_o for 4 cycles at addrs 0-3, 4 ack pulses, FSM back in IDLE, owner_o=00.
REQ-033 Read burst from addr 0x7FE with mem_dat_i=A5A5A5A5 -> addresses 0x7FE, 0x7FF, 0x000; plx_dat_o=A5A5A5A5 with each ack.
REQ-034 Event port burst of 20 words, no last_i -> 16 accesses, then evt_bterm_o pulses with the 16th ack, then IDLE.
REQ-035 Both requests asserted for three consecutive bursts -> with macro: grants PLX, EVT, PLX; without macro: PLX, PLX, PLX.
REQ-036 rst_i asserted on the 2nd word of a PLX burst -> on the next cycle all outputs are 0, no ack for that word, owner_o=00.
REQ-037 PLX req dropped mid-burst without last_i -> mem_en_o is 0 that cycle, FSM in IDLE, and a pending event request is granted after one turnaround cycle.
